mul_share_arbiter: RTL and testbench

Round-robin scheduler that shares one registered-input integer multiplier (1-cycle: operands captured on `regenable`, product combinational from the registers) among `NREQ` requesters in the tensor pipeline. It accepts per-requester operand requests with valid/ready handshakes and drives the multiplier's enable and operands. It tracks the in-flight product's owner and returns each product through a registered, back-pressurable response port tagged with the requester id. Sustains one product per cycle when not back-pressured.

---
 rtl/mul_share_arbiter.sv | 135 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one registered-input multiplier among NREQ requesters.
// Define MUL_SHARE_ARB_PERF_EN to build the grant/stall performance counters.
module mul_share_arbiter #(
  parameter  int LEN  = 32,
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*LEN-1:0] req_a,
  input  logic [NREQ*LEN-1:0] req_b,
  output logic                mul_en,
  output logic [LEN-1:0]      mul_a,
  output logic [LEN-1:0]      mul_b,
  input  logic [2*LEN-1:0]    mul_result,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*LEN-1:0]    rsp_data,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [31:0]         perf_grant_cnt,
  output logic [31:0]         perf_stall_cnt
);

  logic             s1Valid_q, s1Valid_d;
  logic [IDW-1:0]   s1Id_q, s1Id_d;
  logic             rspValid_q, rspValid_d;
  logic [IDW-1:0]   rspId_q, rspId_d;
  logic [2*LEN-1:0] rspData_q, rspData_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             advance;
  logic             found;
  logic [IDW-1:0]   winId;
  logic [NREQ-1:0]  grant;
  int               scanIdx;

  // Both stages move together, so a blocked response freezes the whole pipe.
  assign advance = !rspValid_q || rsp_ready[rspId_q];

  always_comb begin
    found   = 1'b0;
    winId   = '0;
    scanIdx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[scanIdx]) begin
        found = 1'b1;
        winId = IDW'(scanIdx);
      end
    end
  end

  always_comb begin
    grant = '0;
    mul_a = '0;
    mul_b = '0;
    if (!rst && advance && found) begin
      grant[winId] = 1'b1;
      mul_a        = req_a[winId*LEN +: LEN];
      mul_b        = req_b[winId*LEN +: LEN];
    end
  end

  assign req_ready = grant;
  assign mul_en    = |grant;

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Id_d     = s1Id_q;
    rspValid_d = rspValid_q;
    rspId_d    = rspId_q;
    rspData_d  = rspData_q;
    ptr_d      = ptr_q;
    if (advance) begin
      rspValid_d = s1Valid_q;
      rspId_d    = s1Id_q;
      rspData_d  = mul_result;
      s1Valid_d  = |grant;
      s1Id_d     = winId;
    end
    if (|grant) begin
      ptr_d = (int'(winId) == NREQ - 1) ? '0 : winId + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Id_q     <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspData_q  <= '0;
      ptr_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Id_q     <= s1Id_d;
      rspValid_q <= rspValid_d;
      rspId_q    <= rspId_d;
      rspData_q  <= rspData_d;
      ptr_q      <= ptr_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspData_q;

`ifdef MUL_SHARE_ARB_PERF_EN
  logic [31:0] grantCnt_q;
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grantCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (|grant) begin
        grantCnt_q <= grantCnt_q + 32'd1;
      end
      if (|req_valid && !(|grant)) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
    end
  end

  assign perf_grant_cnt = grantCnt_q;
  assign perf_stall_cnt = stallCnt_q;
`else
  assign perf_grant_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural registered-input multiplier.
module tb_mul_share_arbiter;

  localparam int LEN  = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*LEN-1:0] req_a;
  logic [NREQ*LEN-1:0] req_b;
  logic                mul_en;
  logic [LEN-1:0]      mul_a;
  logic [LEN-1:0]      mul_b;
  logic [2*LEN-1:0]    mul_result;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*LEN-1:0]    rsp_data;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         perf_grant_cnt;
  logic [31:0]         perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  mul_share_arbiter #(.LEN(LEN), .NREQ(NREQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .mul_en         (mul_en),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_result     (mul_result),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_ready      (rsp_ready),
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // Shared multiplier: operands captured on mul_en, product combinational from the registers.
  logic [LEN-1:0] mulRegA;
  logic [LEN-1:0] mulRegB;

  always_ff @(posedge clk) begin
    if (mul_en) begin
      mulRegA <= mul_a;
      mulRegB <= mul_b;
    end
  end

  assign mul_result = {{LEN{1'b0}}, mulRegA} * {{LEN{1'b0}}, mulRegB};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic setOperands(input int idx, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    req_a[idx*LEN +: LEN] = a;
    req_b[idx*LEN +: LEN] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    #2;
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset_rsp_data", rsp_data, 64'd0);
    checkOutput("reset_perf_grant", 64'(perf_grant_cnt), 64'd0);
    checkOutput("reset_perf_stall", 64'(perf_stall_cnt), 64'd0);
    for (int i = 0; i < NREQ; i++) setOperands(i, 32'(i + 2), 32'(i + 5));
    applyStimulus(4'b1111, 4'b1111);
    #1;
    checkOutput("reset_forces_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_forces_mul_en", 64'(mul_en), 64'd0);
    checkOutput("reset_forces_mul_a", 64'(mul_a), 64'd0);
    tick();
    rst = 1'b0;

    $display("[TB] contention: all requesters valid from pointer 0");
    for (int c = 0; c < 8; c++) begin
      applyStimulus((c < 5) ? 4'b1111 : 4'b0000, 4'b1111);
      #1;
      if (c < 5) begin
        checkOutput("contention_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      end
      if (c >= 2 && c < 7) begin
        checkOutput("contention_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("contention_rsp_id", 64'(rsp_id), 64'((c - 2) % 4));
        checkOutput("contention_rsp_data", rsp_data,
                    64'((((c - 2) % 4) + 2) * (((c - 2) % 4) + 5)));
      end else begin
        checkOutput("contention_rsp_idle", 64'(rsp_valid), 64'd0);
      end
      tick();
    end

    $display("[TB] single request on requester 2");
    setOperands(2, 32'd7, 32'd6);
    applyStimulus(4'b0100, 4'b1111);
    #1;
    checkOutput("single_req_ready", 64'(req_ready), 64'(4'b0100));
    checkOutput("single_mul_en", 64'(mul_en), 64'd1);
    checkOutput("single_mul_a", 64'(mul_a), 64'd7);
    checkOutput("single_mul_b", 64'(mul_b), 64'd6);
    tick();
    applyStimulus(4'b0000, 4'b1111);
    #1;
    checkOutput("single_latency_not_early", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("single_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("single_rsp_id", 64'(rsp_id), 64'd2);
    checkOutput("single_rsp_data", rsp_data, 64'd42);

    $display("[TB] full-width operands on requester 1");
    setOperands(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(4'b0010, 4'b1111);
    #1;
    checkOutput("wide_req_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    applyStimulus(4'b0000, 4'b1111);
    tick();
    checkOutput("wide_rsp_id", 64'(rsp_id), 64'd1);
    checkOutput("wide_rsp_data", rsp_data, 64'hFFFF_FFFE_0000_0001);

    $display("[TB] back-pressure with both stages occupied");
    setOperands(0, 32'd3, 32'd4);
    setOperands(3, 32'd5, 32'd6);
    setOperands(1, 32'd9, 32'd9);
    applyStimulus(4'b0001, 4'b1111);
    #1;
    checkOutput("bp_first_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    applyStimulus(4'b1000, 4'b1111);
    #1;
    checkOutput("bp_second_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    for (int s = 0; s < 3; s++) begin
      applyStimulus(4'b0110, 4'b1110);
      #1;
      checkOutput("bp_hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_hold_id", 64'(rsp_id), 64'd0);
      checkOutput("bp_hold_data", rsp_data, 64'd12);
      checkOutput("bp_no_grant", 64'(req_ready), 64'd0);
      checkOutput("bp_mul_en_low", 64'(mul_en), 64'd0);
      checkOutput("bp_mul_a_zero", 64'(mul_a), 64'd0);
      tick();
    end
    applyStimulus(4'b0110, 4'b1111);
    #1;
    checkOutput("bp_release_grant", 64'(req_ready), 64'(4'b0010));
    checkOutput("bp_release_mul_en", 64'(mul_en), 64'd1);
    checkOutput("bp_release_data", rsp_data, 64'd12);
    tick();
    applyStimulus(4'b0000, 4'b1111);
    #1;
    checkOutput("bp_queued_id", 64'(rsp_id), 64'd3);
    checkOutput("bp_queued_data", rsp_data, 64'd30);
    tick();
    checkOutput("bp_next_valid", 64'(rsp_valid), 64'd1);
    checkOutput("bp_next_id", 64'(rsp_id), 64'd1);
    checkOutput("bp_next_data", rsp_data, 64'd81);
    tick();
    checkOutput("bp_drained", 64'(rsp_valid), 64'd0);

    $display("[TB] reset in the middle of a stream");
    applyStimulus(4'b1111, 4'b1111);
    tick();
    tick();
    checkOutput("midrst_pre_valid", 64'(rsp_valid), 64'd1);
    checkOutput("midrst_pre_id", 64'(rsp_id), 64'd2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_async_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_async_id", 64'(rsp_id), 64'd0);
    checkOutput("midrst_async_data", rsp_data, 64'd0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("midrst_mul_en", 64'(mul_en), 64'd0);
    tick();
    rst = 1'b0;
    applyStimulus(4'b1010, 4'b1111);
    #1;
    checkOutput("midrst_first_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    applyStimulus(4'b0000, 4'b1111);
    #1;
    checkOutput("midrst_inflight_dropped", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("midrst_rsp_id", 64'(rsp_id), 64'd1);
    checkOutput("midrst_rsp_data", rsp_data, 64'd81);

    $display("[TB] performance counters");
    rst = 1'b1;
    #1;
    checkOutput("perf_cleared_grant", 64'(perf_grant_cnt), 64'd0);
    checkOutput("perf_cleared_stall", 64'(perf_stall_cnt), 64'd0);
    tick();
    rst = 1'b0;
    setOperands(0, 32'd11, 32'd13);
    applyStimulus(4'b0001, 4'b0000);
    repeat (10) tick();
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("perf_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("perf_rsp_data", rsp_data, 64'd143);
`ifdef MUL_SHARE_ARB_PERF_EN
    checkOutput("perf_grant_cnt", 64'(perf_grant_cnt), 64'd2);
    checkOutput("perf_stall_cnt", 64'(perf_stall_cnt), 64'd8);
`else
    checkOutput("perf_grant_cnt_off", 64'(perf_grant_cnt), 64'd0);
    checkOutput("perf_stall_cnt_off", 64'(perf_stall_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
